// File: rtl/decode_stage_pkg.sv
// Shared encodings and instruction field layout for the decode stage.
package decode_stage_pkg;

  localparam int unsigned DS_WIDTH  = 32;
  localparam int unsigned DS_NREGS  = 32;
  localparam int unsigned DS_IMM_W  = 13;
  localparam int unsigned DS_REG_AW = 5;

  // ALU opcodes; values outside this set are passed through untouched.
  typedef enum logic [4:0] {
    OP_NOP = 5'h00,
    OP_ADD = 5'h01,
    OP_SUB = 5'h02,
    OP_AND = 5'h03,
    OP_OR  = 5'h04,
    OP_XOR = 5'h05,
    OP_SHL = 5'h06,
    OP_SHR = 5'h07,
    OP_CMP = 5'h08
  } opcode_e;

  // Compare conditions, only meaningful alongside OP_CMP.
  typedef enum logic [2:0] {
    CC_EQ  = 3'd0,
    CC_NE  = 3'd1,
    CC_LT  = 3'd2,
    CC_GE  = 3'd3,
    CC_LE  = 3'd4,
    CC_GT  = 3'd5,
    CC_AL  = 3'd6,
    CC_NV  = 3'd7
  } cc_e;

  // Decoded view of an instruction word; rb and imm overlap in the encoding.
  typedef struct packed {
    logic [4:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          ra;
    logic                imm_sel;
    logic [2:0]          cc;
    logic [4:0]          rb;
    logic [DS_IMM_W-1:0] imm;
  } instr_t;

  function automatic instr_t decode_instr(input logic [31:0] w);
    instr_t d;
    d.opcode  = w[31:27];
    d.rd      = w[26:22];
    d.ra      = w[21:17];
    d.imm_sel = w[16];
    d.cc      = w[15:13];
    d.rb      = w[12:8];
    d.imm     = w[12:0];
    return d;
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// Register file: NREGS x WIDTH, two asynchronous reads, one write port, r0 hardwired to zero.
module decode_stage_reg_file #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_a_i,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] rdata_a_o,
  output logic [WIDTH-1:0] rdata_b_o
);

  logic [WIDTH-1:0] mem_q [NREGS];

  // Clear on reset; write any register except r0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous reads with r0 forced to zero.
  always_comb begin
    rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];
  end

endmodule

// File: rtl/decode_stage.sv
// Decode / operand-fetch stage: register read with writeback bypass, busy-bit
// scoreboard for RAW stalls, and a single registered payload towards execute.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DS_WIDTH,
  parameter int unsigned NREGS = DS_NREGS,
  parameter int unsigned IMM_W = DS_IMM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_instr,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [4:0]       ex_opcode,
  output logic [2:0]       ex_cc,
  output logic [WIDTH-1:0] ex_a,
  output logic [WIDTH-1:0] ex_b,
  output logic [4:0]       ex_rd,
  output logic             ex_wr
);

  instr_t           f;
  logic [WIDTH-1:0] rdata_a, rdata_b;
  logic [WIDTH-1:0] opnd_a, opnd_b, imm_ext;
  logic [NREGS-1:0] busy_q, busy_d, busy_set, busy_clr, busy_eff;
  logic             hazard_a, hazard_b, stall, ready_c, issue, wr_d;

  logic             ex_valid_q;
  logic [4:0]       ex_opcode_q, ex_rd_q;
  logic [2:0]       ex_cc_q;
  logic [WIDTH-1:0] ex_a_q, ex_b_q;
  logic             ex_wr_q;

  assign f = decode_instr(if_instr);

  decode_stage_reg_file #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (DS_REG_AW)
  ) u_reg_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (wb_en),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data),
    .raddr_a_i (f.ra),
    .raddr_b_i (f.rb),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b)
  );

  // Operand selection: same-cycle writeback bypass, then immediate mux for B.
  always_comb begin
    imm_ext = {{(WIDTH-IMM_W){f.imm[IMM_W-1]}}, f.imm[IMM_W-1:0]};
    opnd_a  = (wb_en && (wb_addr == f.ra) && (f.ra != '0)) ? wb_data : rdata_a;
    opnd_b  = (wb_en && (wb_addr == f.rb) && (f.rb != '0)) ? wb_data : rdata_b;
    if (f.imm_sel) begin
      opnd_b = imm_ext;
    end
  end

  // Hazard detection, handshake and next scoreboard state.
  always_comb begin
    busy_clr = '0;
    if (wb_en) begin
      busy_clr[wb_addr] = 1'b1;
    end
    // A register retiring this cycle no longer blocks a reader.
    busy_eff = busy_q & ~busy_clr;
    hazard_a = busy_eff[f.ra] && (f.ra != '0);
    hazard_b = !f.imm_sel && busy_eff[f.rb] && (f.rb != '0);
    stall    = if_valid && (hazard_a || hazard_b);
    ready_c  = !flush && !stall && (!ex_valid_q || ex_ready);
    issue    = if_valid && ready_c;
    wr_d     = (f.opcode != OP_NOP) && (f.rd != '0);
    busy_set = '0;
    if (issue && wr_d) begin
      busy_set[f.rd] = 1'b1;
    end
    // Set is applied after clear so a same-register set wins.
    busy_d    = flush ? '0 : (busy_eff | busy_set);
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Output register: flush beats issue, issue beats drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_opcode_q <= '0;
      ex_cc_q     <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_rd_q     <= '0;
      ex_wr_q     <= 1'b0;
    end else if (flush) begin
      ex_valid_q  <= 1'b0;
    end else if (issue) begin
      ex_valid_q  <= 1'b1;
      ex_opcode_q <= f.opcode;
      ex_cc_q     <= f.cc;
      ex_a_q      <= opnd_a;
      ex_b_q      <= opnd_b;
      ex_rd_q     <= f.rd;
      ex_wr_q     <= wr_d;
    end else if (ex_ready) begin
      ex_valid_q  <= 1'b0;
    end
  end

  assign if_ready  = ready_c;
  assign ex_valid  = ex_valid_q;
  assign ex_opcode = ex_opcode_q;
  assign ex_cc     = ex_cc_q;
  assign ex_a      = ex_a_q;
  assign ex_b      = ex_b_q;
  assign ex_rd     = ex_rd_q;
  assign ex_wr     = ex_wr_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_AND = 5'h03;
  localparam logic [4:0] OP_OR  = 5'h04;
  localparam logic [4:0] OP_XOR = 5'h05;
  localparam logic [4:0] OP_CMP = 5'h08;

  logic        clk, rst_n;
  logic        if_valid, if_ready;
  logic [31:0] if_instr;
  logic        flush, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid, ex_ready;
  logic [4:0]  ex_opcode, ex_rd;
  logic [2:0]  ex_cc;
  logic [31:0] ex_a, ex_b;
  logic        ex_wr;

  int total = 0;
  int bad   = 0;

  decode_stage #(.WIDTH(32), .NREGS(32), .IMM_W(13)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_opcode(ex_opcode), .ex_cc(ex_cc), .ex_a(ex_a), .ex_b(ex_b),
    .ex_rd(ex_rd), .ex_wr(ex_wr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] ra,
                                     input logic sel, input logic [2:0] cc, input logic [12:0] low);
    return {op, rd, ra, sel, cc, low};
  endfunction

  function automatic logic [31:0] mkr(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] ra,
                                      input logic [4:0] rb);
    return mk(op, rd, ra, 1'b0, 3'd0, {rb, 8'h00});
  endfunction

  function automatic logic [31:0] mki(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] ra,
                                      input logic [12:0] imm);
    return mk(op, rd, ra, 1'b1, 3'd0, imm);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ex_valid); end
    total++; if (ex_a !== 32'h0) begin bad++; $display("FAIL rst_a got=%h exp=0", ex_a); end
    total++; if (ex_wr !== 1'b0) begin bad++; $display("FAIL rst_wr got=%b exp=0", ex_wr); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", if_ready); end
    step();
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h55;
    step();
    wb_en = 1'b0;
    if_valid = 1'b1; if_instr = mkr(OP_ADD, 5'd1, 5'd4, 5'd4);
    step();
    total++; if (ex_a !== 32'h55) begin bad++; $display("FAIL rst_pre_a got=%h exp=55", ex_a); end
    // Reset in the middle of a handshake with a write pending.
    if_instr = mki(OP_ADD, 5'd2, 5'd0, 13'h1);
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h99;
    #2 rst_n = 1'b0;
    #1;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", ex_valid); end
    total++; if (ex_a !== 32'h0) begin bad++; $display("FAIL rst_mid_a got=%h exp=0", ex_a); end
    step();
    if_valid = 1'b0; wb_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL rst_rel_ready got=%b exp=1", if_ready); end
    // r6 write dropped by reset; busy[1] cleared by reset.
    if_valid = 1'b1; if_instr = mkr(OP_ADD, 5'd0, 5'd6, 5'd1);
    #1;
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL rst_busy_ready got=%b exp=1", if_ready); end
    step();
    if_valid = 1'b0;
    total++; if (ex_a !== 32'h0) begin bad++; $display("FAIL rst_nowrite_a got=%h exp=0", ex_a); end
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL rst_issue_valid got=%b exp=1", ex_valid); end
    step();
  endtask

  task automatic test_imm_issue();
    if_valid = 1'b1; if_instr = mki(OP_ADD, 5'd3, 5'd0, 13'h1FFF);
    @(negedge clk);
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL imm_ready got=%b exp=1", if_ready); end
    step();
    if_valid = 1'b0;
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL imm_valid got=%b exp=1", ex_valid); end
    total++; if (ex_opcode !== OP_ADD) begin bad++; $display("FAIL imm_op got=%h exp=%h", ex_opcode, OP_ADD); end
    total++; if (ex_a !== 32'h0) begin bad++; $display("FAIL imm_a got=%h exp=0", ex_a); end
    total++; if (ex_b !== 32'hFFFFFFFF) begin bad++; $display("FAIL imm_b got=%h exp=ffffffff", ex_b); end
    total++; if (ex_rd !== 5'd3) begin bad++; $display("FAIL imm_rd got=%0d exp=3", ex_rd); end
    total++; if (ex_wr !== 1'b1) begin bad++; $display("FAIL imm_wr got=%b exp=1", ex_wr); end
    if_valid = 1'b1; if_instr = mkr(OP_ADD, 5'd0, 5'd3, 5'd0);
    @(negedge clk);
    total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL imm_busy3 got=%b exp=0", if_ready); end
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h12;
    #1;
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL imm_clr_ready got=%b exp=1", if_ready); end
    step();
    if_valid = 1'b0; wb_en = 1'b0;
    total++; if (ex_a !== 32'h12) begin bad++; $display("FAIL imm_bypass_a got=%h exp=12", ex_a); end
    step();
  endtask

  task automatic test_raw();
    if_valid = 1'b1; if_instr = mki(OP_ADD, 5'd5, 5'd0, 13'h1);
    step();
    if_instr = mki(OP_SUB, 5'd6, 5'd5, 13'h2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL raw_stall%0d got=%b exp=0", i, if_ready); end
      step();
    end
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h7;
    @(negedge clk);
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL raw_release got=%b exp=1", if_ready); end
    step();
    if_valid = 1'b0; wb_en = 1'b0;
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL raw_valid got=%b exp=1", ex_valid); end
    total++; if (ex_a !== 32'h7) begin bad++; $display("FAIL raw_a got=%h exp=7", ex_a); end
    total++; if (ex_b !== 32'h2) begin bad++; $display("FAIL raw_b got=%h exp=2", ex_b); end
    total++; if (ex_opcode !== OP_SUB) begin bad++; $display("FAIL raw_op got=%h exp=%h", ex_opcode, OP_SUB); end
    // busy[6] now set: immediate form ignores rb bits, register form stalls on rb.
    if_valid = 1'b1; if_instr = mki(OP_ADD, 5'd0, 5'd0, {5'd6, 8'h00});
    @(negedge clk);
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL raw_immsel got=%b exp=1", if_ready); end
    if_instr = mkr(OP_ADD, 5'd0, 5'd0, 5'd6);
    #1;
    total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL raw_rb_stall got=%b exp=0", if_ready); end
    if_valid = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
    step();
    wb_en = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    ex_ready = 1'b0;
    if_valid = 1'b1; if_instr = mki(OP_OR, 5'd7, 5'd0, 13'h0AA);
    step();
    if_instr = mki(OP_XOR, 5'd8, 5'd0, 13'h055);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d got=%b exp=1", i, ex_valid); end
      total++; if (ex_b !== 32'hAA) begin bad++; $display("FAIL bp_b%0d got=%h exp=aa", i, ex_b); end
      total++; if (ex_rd !== 5'd7) begin bad++; $display("FAIL bp_rd%0d got=%0d exp=7", i, ex_rd); end
      total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d got=%b exp=0", i, if_ready); end
      step();
    end
    ex_ready = 1'b1;
    @(negedge clk);
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL bp_resume got=%b exp=1", if_ready); end
    step();
    total++; if (ex_b !== 32'h55) begin bad++; $display("FAIL bp_b2 got=%h exp=55", ex_b); end
    total++; if (ex_opcode !== OP_XOR) begin bad++; $display("FAIL bp_op2 got=%h exp=%h", ex_opcode, OP_XOR); end
    if_instr = mki(OP_AND, 5'd0, 5'd0, 13'h1);
    @(negedge clk);
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL bp_b2b_ready got=%b exp=1", if_ready); end
    step();
    if_valid = 1'b0;
    total++; if (ex_rd !== 5'd0) begin bad++; $display("FAIL bp_rd3 got=%0d exp=0", ex_rd); end
    total++; if (ex_wr !== 1'b0) begin bad++; $display("FAIL bp_wr3 got=%b exp=0", ex_wr); end
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL bp_valid3 got=%b exp=1", ex_valid); end
    step();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", ex_valid); end
  endtask

  task automatic test_flush();
    ex_ready = 1'b0;
    if_valid = 1'b1; if_instr = mki(OP_ADD, 5'd9, 5'd0, 13'h3);
    step();
    total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL fl_pre_valid got=%b exp=1", ex_valid); end
    flush = 1'b1;
    if_instr = mki(OP_ADD, 5'd0, 5'd0, 13'h4);
    wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'hABC;
    @(negedge clk);
    total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL fl_ready got=%b exp=0", if_ready); end
    step();
    flush = 1'b0; if_valid = 1'b0; wb_en = 1'b0;
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%b exp=0", ex_valid); end
    ex_ready = 1'b1;
    if_valid = 1'b1; if_instr = mkr(OP_ADD, 5'd0, 5'd9, 5'd7);
    @(negedge clk);
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL fl_busy97 got=%b exp=1", if_ready); end
    step();
    total++; if (ex_a !== 32'h0) begin bad++; $display("FAIL fl_r9 got=%h exp=0", ex_a); end
    if_instr = mkr(OP_ADD, 5'd0, 5'd10, 5'd8);
    @(negedge clk);
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL fl_busy8 got=%b exp=1", if_ready); end
    step();
    if_valid = 1'b0;
    total++; if (ex_a !== 32'hABC) begin bad++; $display("FAIL fl_wb_kept got=%h exp=abc", ex_a); end
    step();
  endtask

  task automatic test_r0();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h5;
    step();
    wb_en = 1'b0;
    if_valid = 1'b1; if_instr = mkr(OP_ADD, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL r0_ready got=%b exp=1", if_ready); end
    step();
    total++; if (ex_a !== 32'h0) begin bad++; $display("FAIL r0_a got=%h exp=0", ex_a); end
    total++; if (ex_wr !== 1'b0) begin bad++; $display("FAIL r0_wr got=%b exp=0", ex_wr); end
    if_instr = mkr(OP_SUB, 5'd0, 5'd0, 5'd0);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h9;
    @(negedge clk);
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL r0_nostall got=%b exp=1", if_ready); end
    step();
    if_valid = 1'b0; wb_en = 1'b0;
    total++; if (ex_a !== 32'h0) begin bad++; $display("FAIL r0_nobypass got=%h exp=0", ex_a); end
    total++; if (ex_opcode !== OP_SUB) begin bad++; $display("FAIL r0_op got=%h exp=%h", ex_opcode, OP_SUB); end
    step();
  endtask

  task automatic test_passthru();
    if_valid = 1'b1; if_instr = mk(5'h1F, 5'd11, 5'd0, 1'b1, 3'd0, 13'h010);
    step();
    total++; if (ex_opcode !== 5'h1F) begin bad++; $display("FAIL pt_op got=%h exp=1f", ex_opcode); end
    total++; if (ex_wr !== 1'b1) begin bad++; $display("FAIL pt_wr got=%b exp=1", ex_wr); end
    total++; if (ex_b !== 32'h10) begin bad++; $display("FAIL pt_b got=%h exp=10", ex_b); end
    if_instr = mkr(OP_ADD, 5'd0, 5'd11, 5'd0);
    @(negedge clk);
    total++; if (if_ready !== 1'b1 - 1'b1) begin bad++; $display("FAIL pt_busy11 got=%b exp=0", if_ready); end
    if_instr = mk(OP_CMP, 5'd0, 5'd0, 1'b0, 3'd5, {5'd13, 8'h00});
    wb_en = 1'b1; wb_addr = 5'd13; wb_data = 32'h3C;
    step();
    if_instr = mki(OP_NOP, 5'd12, 5'd0, 13'h0);
    wb_en = 1'b1; wb_addr = 5'd11; wb_data = 32'h0;
    total++; if (ex_opcode !== OP_CMP) begin bad++; $display("FAIL pt_cmp_op got=%h exp=%h", ex_opcode, OP_CMP); end
    total++; if (ex_cc !== 3'd5) begin bad++; $display("FAIL pt_cc got=%0d exp=5", ex_cc); end
    total++; if (ex_b !== 32'h3C) begin bad++; $display("FAIL pt_rb_bypass got=%h exp=3c", ex_b); end
    total++; if (ex_wr !== 1'b0) begin bad++; $display("FAIL pt_cmp_wr got=%b exp=0", ex_wr); end
    step();
    wb_en = 1'b0;
    total++; if (ex_opcode !== OP_NOP) begin bad++; $display("FAIL pt_nop_op got=%h exp=0", ex_opcode); end
    total++; if (ex_rd !== 5'd12) begin bad++; $display("FAIL pt_nop_rd got=%0d exp=12", ex_rd); end
    total++; if (ex_wr !== 1'b0) begin bad++; $display("FAIL pt_nop_wr got=%b exp=0", ex_wr); end
    if_instr = mkr(OP_ADD, 5'd0, 5'd12, 5'd11);
    @(negedge clk);
    total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL pt_nop_nobusy got=%b exp=1", if_ready); end
    step();
    if_valid = 1'b0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_ready = 1'b1;
    test_reset();
    test_imm_issue();
    test_raw();
    test_backpressure();
    test_flush();
    test_r0();
    test_passthru();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
